// File: rtl/layer_mac_array.sv
// Per-lane two-stage multiply-accumulate array with a write-out sequencer that
// emits activated Q8.8 results one lane per cycle and tracks the output-layer argmax.
module layer_mac_array #(
  parameter int unsigned NEURONS = 20,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ACC_W   = 40
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [2:0]                Layer,
  input  logic [2:0]                Active,
  input  logic                      ActFuncActive,
  input  logic                      R,
  input  logic signed [DATA_W-1:0]  In_data,
  input  logic [NEURONS*DATA_W-1:0] Weights,
  output logic                      Out_we,
  output logic [4:0]                Out_addr,
  output logic [DATA_W-1:0]         Out_data,
  output logic                      Layer_done,
  output logic [3:0]                Digit,
  output logic                      Digit_valid
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned FRAC_W = 8;
  localparam logic [IDX_W-1:0] LAST_FULL = IDX_W'(NEURONS - 1);
  localparam logic [IDX_W-1:0] LAST_OUT  = IDX_W'(9);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                   state, state_n;
  logic [IDX_W-1:0]         idx, idx_n, last;
  logic                     layer_ok, layer_out, mac_en, clear;
  logic [2:0]               layer_q;
  logic                     p_valid;
  logic signed [PROD_W-1:0] prod [NEURONS];
  logic signed [ACC_W-1:0]  acc  [NEURONS];
  logic                     afa_q, afa_rise, armed, start, r_q;
  logic                     we_c, done_c;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] data_c;
  logic signed [DATA_W-1:0] max_val;
  logic [3:0]               max_idx;
  logic                     done_q, digit_set;

  assign layer_ok  = (Layer == 3'b001) || (Layer == 3'b010) || (Layer == 3'b100);
  assign layer_out = (Layer == 3'b100);
  assign last      = layer_out ? LAST_OUT : LAST_FULL;
  assign mac_en    = layer_ok && (Active == Layer) && !ActFuncActive;
  assign clear     = R || (Layer != layer_q);
  assign afa_rise  = ActFuncActive && !afa_q;
  // A window that opens while a product is still in flight waits for it to land.
  assign start     = (afa_rise || armed) && layer_ok && !p_valid;

  // Stage 1: per-lane product register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      p_valid <= 1'b0;
      for (int i = 0; i < NEURONS; i++) prod[i] <= '0;
    end else begin
      p_valid <= mac_en;
      if (mac_en) begin
        for (int i = 0; i < NEURONS; i++)
          prod[i] <= PROD_W'(In_data) * PROD_W'($signed(Weights[i*DATA_W +: DATA_W]));
      end
    end
  end

  // Stage 2: wrapping accumulate; clear wins over an arriving product
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NEURONS; i++) acc[i] <= '0;
    end else begin
      for (int i = 0; i < NEURONS; i++) begin
        if (clear)        acc[i] <= '0;
        else if (p_valid) acc[i] <= acc[i] + ACC_W'(prod[i]);
      end
    end
  end

  // Edge trackers; afa_q resets high so a window held across reset never restarts
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      layer_q <= '0;
      afa_q   <= 1'b1;
      armed   <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      layer_q <= Layer;
      afa_q   <= ActFuncActive;
      r_q     <= R;
      armed   <= (state == IDLE) && ActFuncActive && (afa_rise || armed) && !start;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    we_c    = 1'b0;
    done_c  = 1'b0;
    case (state)
      IDLE: begin
        idx_n = '0;
        if (start) state_n = WRITE;
      end
      WRITE: begin
        if (!ActFuncActive) begin
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          we_c = 1'b1;
          if (idx == last) begin
            state_n = DONE;
            done_c  = 1'b1;
            idx_n   = '0;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      DONE: if (!ActFuncActive) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Q16.16 accumulator back to Q8.8, saturate, then ReLU on hidden layers
  always_comb begin
    shifted = acc[idx] >>> FRAC_W;
    data_c  = '0;
    if (shifted > SAT_MAX)      data_c = DATA_W'(SAT_MAX);
    else if (shifted < SAT_MIN) data_c = DATA_W'(SAT_MIN);
    else                        data_c = DATA_W'(shifted);
    if (!layer_out && data_c[DATA_W-1]) data_c = '0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Out_we      <= 1'b0;
      Out_addr    <= '0;
      Out_data    <= '0;
      done_q      <= 1'b0;
      Layer_done  <= 1'b0;
      digit_set   <= 1'b0;
      Digit       <= '0;
      Digit_valid <= 1'b0;
      max_val     <= '0;
      max_idx     <= '0;
    end else begin
      Out_we     <= we_c;
      Out_addr   <= we_c ? idx : '0;
      Out_data   <= we_c ? data_c : '0;
      done_q     <= done_c;
      Layer_done <= done_q;
      digit_set  <= done_c && layer_out;
      // Strict compare keeps the lower index on ties
      if (we_c && ((idx == '0) || (data_c > max_val))) begin
        max_val <= data_c;
        max_idx <= idx[3:0];
      end
      if (digit_set) begin
        Digit       <= max_idx;
        Digit_valid <= 1'b1;
      end else if (R && !r_q) begin
        Digit_valid <= 1'b0;
      end
    end
  end

endmodule
